input_port_ctrl: RTL and testbench
==================================

# input_port_ctrl

Input-port peripheral that produces the 32-bit value the datapath reads on `INPort_In`. It synchronizes and debounces a bank of board switches and a load push-button, and captures the switch value on each debounced button press. It presents the value with a `DataReady` flag that the processor consumes via the control unit's `Strobe` pulse. It runs on the same divided operating clock as the datapath and control unit.

## Interface
- `SW_WIDTH`, default 8: number of raw switch inputs, zero-extended to 32 bits on output.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before the button level is accepted. Legal values are ≥ 2; synthesis uses a large value, benches use 4.

Ports:
- `Clock`, in, 1: operating clock; all state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `Switches`, in, `SW_WIDTH`: raw asynchronous switch levels.
- `LoadBtn`, in, 1: raw asynchronous push-button, active-high.
- `Strobe`, in, 1: synchronous consume pulse from the control unit; the processor has read the port.
- `INPort_Data`, out, 32: captured value; bits [SW_WIDTH-1:0] hold the switches, upper bits are 0.
- `DataReady`, out, 1: captured value has not yet been consumed.
- `Overrun`, out, 1: sticky; a press was dropped because unconsumed data was pending.

## Operation
- Synchronizers:
  - 2-flop synchronizer on `LoadBtn`, giving `btn_s`.
  - 2-flop synchronizer on each `Switches` bit, giving `sw_s`.
- Debouncer: register `btn_stable` with a counter `cnt` of width ceil(log2(`DEBOUNCE_CYCLES`)).
  - If `btn_s` == `btn_stable`: `cnt` <= 0.
  - Else if `cnt` == `DEBOUNCE_CYCLES`-1: `btn_stable` <= `btn_s` and `cnt` <= 0.
  - Else: `cnt` <= `cnt`+1.
  - A disagreement lasting fewer than `DEBOUNCE_CYCLES` cycles never changes `btn_stable`.
- Press event: `press` = `btn_stable` & ~`btn_stable_q`, where `btn_stable_q` is `btn_stable` delayed one cycle. Releases generate no event.
- State machine, states EMPTY (`DataReady`=0) and FULL (`DataReady`=1):
  - EMPTY, `press`: `INPort_Data` <= {0, `sw_s`}; go to FULL.
  - EMPTY, `Strobe`: ignored; stay EMPTY.
  - FULL, `Strobe` without `press`: go to EMPTY. `INPort_Data` keeps its value; the value is not cleared.
  - FULL, `press` without `Strobe`: data is not overwritten; `Overrun` <= 1; stay FULL.
  - FULL, `Strobe` and `press` in the same cycle: the old value counts as consumed and the new value is captured; stay FULL; `Overrun` unchanged.
  - A multi-cycle `Strobe` is treated as a level. Every cycle it is high in FULL counts as a consume.
- `Overrun` clears only on `Reset`.
- Reset values, applied asynchronously on assertion of `Reset`:
  - `INPort_Data`=0, `DataReady`=0, `Overrun`=0, state EMPTY.
  - Synchronizer flops, `btn_stable`, `btn_stable_q` and `cnt` all 0.
  - A button held through reset release is therefore reported as a new press once debounced.

## Timing
- `LoadBtn` sampling: call the first rising edge that samples `LoadBtn` high E0.
  - `btn_s` is high after E1.
  - `btn_stable` rises at E(1+`DEBOUNCE_CYCLES`).
  - `DataReady` and `INPort_Data` update at E(2+`DEBOUNCE_CYCLES`); this is E6 for the default of 4.
- Captured switch value: `sw_s` at the capture edge, which is the `Switches` level sampled two edges earlier. Switches must be held for at least 3 cycles around the press.
- Consume: `DataReady` falls on the same rising edge at which `Strobe` is sampled high.
- Output timing: all outputs are registered; no combinational path from inputs to outputs.
- `Reset` mid-debounce or mid-FULL: everything clears immediately. Any press in progress is re-debounced from `cnt`=0 after `Reset` deasserts.

## Test plan
- Reset, then `Switches`=8'hC0 and `LoadBtn` held high from E0 → `DataReady`=1 and `INPort_Data`=32'h000000C0 exactly at E6, not before.
- `LoadBtn` glitch high for 3 cycles with `DEBOUNCE_CYCLES`=4 → `btn_stable` stays 0, `DataReady` stays 0, `INPort_Data` stays 0.
- FULL with value 8'hC0; pulse `Strobe` for one cycle → `DataReady`=0 on that edge, `INPort_Data` still 32'hC0; a further `Strobe` while EMPTY has no effect.
- FULL with value 8'h12; second press with `Switches`=8'h34 and no `Strobe` → `INPort_Data` stays 32'h12, `Overrun`=1 and remains 1 after a later `Strobe`.
- FULL with value 8'h12; `Strobe` asserted in the same cycle as a `press` with `Switches`=8'h56 → `DataReady` stays 1, `INPort_Data`=32'h56, `Overrun`=0.
- `Reset` asserted mid-debounce and again while FULL → all outputs are 0 immediately, without waiting for a clock edge. Button held through reset release → one press reported at E6 after the first post-reset sample.

Source files
------------

// File: rtl/input_port_ctrl_if.sv
// rtl/input_port_ctrl_if.sv - switch/button input port signal bundle
interface input_port_ctrl_if #(
    parameter int SW_WIDTH = 8
);
    logic [SW_WIDTH-1:0] Switches;
    logic                LoadBtn;
    logic                Strobe;
    logic [31:0]         INPort_Data;
    logic                DataReady;
    logic                Overrun;

    // Board/control side: drives the raw levels and the consume strobe
    modport master (
        output Switches,
        output LoadBtn,
        output Strobe,
        input  INPort_Data,
        input  DataReady,
        input  Overrun
    );

    // Peripheral side
    modport slave (
        input  Switches,
        input  LoadBtn,
        input  Strobe,
        output INPort_Data,
        output DataReady,
        output Overrun
    );
endinterface

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - synchronized, debounced switch capture port with DataReady/Overrun
module input_port_ctrl #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic          Clock,
    input logic          Reset,
    input_port_ctrl_if.slave port
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic                btn_m;
    logic                btn_s;
    logic [SW_WIDTH-1:0] sw_m;
    logic [SW_WIDTH-1:0] sw_s;
    logic                btn_stable;
    logic                btn_stable_q;
    logic [CNT_W-1:0]    cnt;
    logic                press;
    state_t              state;
    logic [31:0]         data_q;
    logic                ready_q;
    logic                overrun_q;

    // Two-flop synchronizers for the asynchronous button and switch levels
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= '0;
            sw_s  <= '0;
        end else begin
            btn_m <= port.LoadBtn;
            btn_s <= btn_m;
            sw_m  <= port.Switches;
            sw_s  <= sw_m;
        end
    end

    // Debouncer: accept a new button level only after it disagrees for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            btn_stable   <= 1'b0;
            btn_stable_q <= 1'b0;
            cnt          <= '0;
        end else begin
            btn_stable_q <= btn_stable;
            if (btn_s == btn_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                btn_stable <= btn_s;
                cnt        <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level is a press; releases are ignored
    assign press = btn_stable & ~btn_stable_q;

    // EMPTY/FULL holding register; a same-cycle consume and press replaces the value without overrun
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= EMPTY;
            data_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (press) begin
                        data_q  <= 32'(sw_s);
                        ready_q <= 1'b1;
                        state   <= FULL;
                    end
                end
                FULL: begin
                    if (press && port.Strobe) begin
                        data_q <= 32'(sw_s);
                    end else if (port.Strobe) begin
                        ready_q <= 1'b0;
                        state   <= EMPTY;
                    end else if (press) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    state   <= EMPTY;
                end
            endcase
        end
    end

    assign port.INPort_Data = data_q;
    assign port.DataReady   = ready_q;
    assign port.Overrun     = overrun_q;
endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - scoreboard bench for input_port_ctrl
module tb_input_port_ctrl;
    logic Clock = 1'b0;
    logic Reset;

    always #5 Clock = ~Clock;

    input_port_ctrl_if #(.SW_WIDTH(8)) bus ();

    input_port_ctrl #(
        .SW_WIDTH(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .port(bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        ready;
        logic        ovr;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc      = 0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [33:0] last     = '0;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: every visible output change outside reset must match the next queued expectation
    always @(negedge Clock) begin
        logic [33:0] cur;
        exp_t        e;
        cur = {bus.INPort_Data, bus.DataReady, bus.Overrun};
        if (Reset) begin
            last = cur;
        end else if (cur !== last) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_change: got cyc=%0d data=%h ready=%b ovr=%b, required no change",
                         cyc, bus.INPort_Data, bus.DataReady, bus.Overrun);
            end else begin
                e = sb.pop_front();
                if (cur === {e.data, e.ready, e.ovr} && cyc == e.cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got cyc=%0d data=%h ready=%b ovr=%b, required cyc=%0d data=%h ready=%b ovr=%b",
                             e.name, cyc, bus.INPort_Data, bus.DataReady, bus.Overrun,
                             e.cyc, e.data, e.ready, e.ovr);
                end
            end
            last = cur;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check_out(input string name, input logic [31:0] d, input logic r, input logic o);
        n_checks++;
        if ({bus.INPort_Data, bus.DataReady, bus.Overrun} === {d, r, o}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got data=%h ready=%b ovr=%b, required data=%h ready=%b ovr=%b",
                     name, bus.INPort_Data, bus.DataReady, bus.Overrun, d, r, o);
        end
    endtask

    // Assert reset between edges and check outputs clear before any clock edge
    task automatic do_reset(input string name);
        @(posedge Clock);
        #3;
        Reset = 1'b1;
        #1;
        check_out(name, 32'h0, 1'b0, 1'b0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // Press held from the next edge (E0); capture expected at E6 = drive cycle + 7
    task automatic press(input logic [7:0] sw, input bit strobe_cap, input string name,
                         input logic [31:0] d, input logic r, input logic o);
        bus.Switches = sw;
        bus.LoadBtn  = 1'b1;
        sb.push_back('{cyc + 7, d, r, o, name});
        if (strobe_cap) begin
            tick(6);
            bus.Strobe = 1'b1;
            tick(1);
            bus.Strobe = 1'b0;
            tick(5);
        end else begin
            tick(12);
        end
        bus.LoadBtn = 1'b0;
        tick(12);
    endtask

    task automatic strobe(input string name, input bit expect_change,
                          input logic [31:0] d, input logic r, input logic o);
        bus.Strobe = 1'b1;
        if (expect_change) sb.push_back('{cyc + 1, d, r, o, name});
        tick(1);
        bus.Strobe = 1'b0;
        tick(2);
    endtask

    initial begin
        Reset        = 1'b1;
        bus.Switches = '0;
        bus.LoadBtn  = 1'b0;
        bus.Strobe   = 1'b0;
        tick(3);
        check_out("reset_state", 32'h0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick(2);

        // Three-cycle glitch must not be accepted
        bus.Switches = 8'hC0;
        bus.LoadBtn  = 1'b1;
        tick(3);
        bus.LoadBtn = 1'b0;
        tick(12);
        check_out("glitch_no_capture", 32'h0, 1'b0, 1'b0);

        // Capture, consume, ignored strobe while empty
        press(8'hC0, 1'b0, "press_c0_at_e6", 32'hC0, 1'b1, 1'b0);
        strobe("strobe_consume", 1'b1, 32'hC0, 1'b0, 1'b0);
        strobe("strobe_empty", 1'b0, 32'h0, 1'b0, 1'b0);
        check_out("empty_strobe_ignored", 32'hC0, 1'b0, 1'b0);

        // Overrun without consume, sticky across a later strobe
        do_reset("reset_clears_data");
        press(8'h12, 1'b0, "press_12", 32'h12, 1'b1, 1'b0);
        press(8'h34, 1'b0, "overrun_press_34", 32'h12, 1'b1, 1'b1);
        strobe("strobe_after_overrun", 1'b1, 32'h12, 1'b0, 1'b1);
        check_out("overrun_sticky", 32'h12, 1'b0, 1'b1);

        // Same-cycle consume and press replaces data without overrun
        do_reset("reset_clears_overrun");
        press(8'h12, 1'b0, "press_12b", 32'h12, 1'b1, 1'b0);
        press(8'h56, 1'b1, "strobe_with_press_56", 32'h56, 1'b1, 1'b0);

        // Reset while FULL with the button held through release
        bus.Switches = 8'hA5;
        bus.LoadBtn  = 1'b1;
        tick(3);
        do_reset("reset_mid_full");
        sb.push_back('{cyc + 7, 32'hA5, 1'b1, 1'b0, "held_through_reset_a5"});
        tick(12);
        bus.LoadBtn = 1'b0;
        tick(12);

        // Reset mid-debounce, button held; must re-debounce from zero
        bus.Switches = 8'h3C;
        bus.LoadBtn  = 1'b1;
        tick(3);
        do_reset("reset_mid_debounce");
        sb.push_back('{cyc + 7, 32'h3C, 1'b1, 1'b0, "redebounce_3c"});
        tick(12);
        bus.LoadBtn = 1'b0;
        tick(12);

        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL missing_events: got %0d pending, required 0 (next %s)", sb.size(), sb[0].name);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
